// File: rtl/galaga_pkg.sv
// galaga_pkg: shared VGA timing, object classes and slot layout for the sprite engine
package galaga_pkg;
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BACK = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BACK = 33;
  localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int CLS_MAX_W = 8;
  typedef enum logic [2:0] {
    CLS_BG = 3'd0,
    CLS_PLAYER = 3'd1,
    CLS_PLAYER_BULLET = 3'd2,
    CLS_ENEMY = 3'd3,
    CLS_ENEMY_BULLET = 3'd4
  } obj_class_e;
  typedef struct packed {
    logic active;
    logic [CLS_MAX_W-1:0] cls;
    logic [9:0] x;
    logic [8:0] y;
    logic [5:0] w;
    logic [5:0] h;
  } obj_slot_t;
endpackage

// File: rtl/galaga_vga_timing.sv
// galaga_vga_timing: raster counters, visible flag, raw syncs and vblank commit strobe
module galaga_vga_timing
  import galaga_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT = VGA_H_FRONT,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BACK = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT = VGA_V_FRONT,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BACK = VGA_V_BACK
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        visible,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        commit
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  logic x_last;
  assign x_last = x == 11'(H_TOTAL - 1);
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_last ? '0 : x + 11'd1;
      if (x_last) y <= (y == 10'(V_TOTAL - 1)) ? '0 : y + 10'd1;
    end
  end
  assign visible = (x < 11'(H_DISPLAY)) && (y < 10'(V_DISPLAY));
  assign hsync_n = !((x >= 11'(H_DISPLAY + H_FRONT)) && (x < 11'(H_DISPLAY + H_FRONT + H_SYNC)));
  assign vsync_n = !((y >= 10'(V_DISPLAY + V_FRONT)) && (y < 10'(V_DISPLAY + V_FRONT + V_SYNC)));
  assign commit = (x == '0) && (y == 10'(V_DISPLAY));
endmodule

// File: rtl/galaga_sprite_engine.sv
// galaga_sprite_engine: per-pixel object hit test with priority, collision tracking and vblank table commit
module galaga_sprite_engine
  import galaga_pkg::*;
#(
  parameter int N_OBJ = 16,
  parameter int CLASS_W = 3,
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT = VGA_H_FRONT,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BACK = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT = VGA_V_FRONT,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BACK = VGA_V_BACK,
  localparam int IDX_W = $clog2(N_OBJ)
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_WrEn,
  input  logic [IDX_W-1:0]   i_WrIdx,
  input  logic               i_WrActive,
  input  logic [CLASS_W-1:0] i_WrClass,
  input  logic [9:0]         i_WrX,
  input  logic [8:0]         i_WrY,
  input  logic [5:0]         i_WrW,
  input  logic [5:0]         i_WrH,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_De,
  output logic [CLASS_W-1:0] o_pixelState,
  output logic [IDX_W-1:0]   o_ObjIdx,
  output logic               o_Hit,
  output logic               o_Collide,
  output logic [N_OBJ-1:0]   o_CollideMask,
  output logic               o_FrameStart
);
  logic [10:0] x;
  logic [9:0] y;
  logic visible, hsync_n, vsync_n, commit;
  obj_slot_t shadow [N_OBJ];
  obj_slot_t live [N_OBJ];
  logic wr_ok;
  logic [N_OBJ-1:0] hit_d, hit1, acc;
  logic hs1, vs1, de1, commit1, multi;
  logic [IDX_W-1:0] win_idx;
  logic [CLS_MAX_W-1:0] win_cls;
  galaga_vga_timing #(
    .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_DISPLAY(V_DISPLAY), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .x(x), .y(y), .visible(visible),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .commit(commit)
  );
  assign wr_ok = i_WrEn && ({1'b0, i_WrIdx} < (IDX_W + 1)'(N_OBJ));
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      shadow <= '{default: '0};
      live <= '{default: '0};
    end else begin
      if (wr_ok) shadow[i_WrIdx] <= '{active: i_WrActive, cls: CLS_MAX_W'(i_WrClass), x: i_WrX, y: i_WrY, w: i_WrW, h: i_WrH};
      if (commit) live <= shadow;
    end
  end
  always_comb begin
    hit_d = '0;
    for (int k = 0; k < N_OBJ; k++)
      hit_d[k] = live[k].active && visible &&
                 ({1'b0, live[k].x} <= x) && (x < {1'b0, live[k].x} + 11'(live[k].w)) &&
                 ({2'b0, live[k].y} <= {1'b0, y}) && ({1'b0, y} < {2'b0, live[k].y} + 11'(live[k].h));
  end
  always_comb begin
    win_idx = '0;
    for (int k = N_OBJ - 1; k >= 0; k--)
      if (hit1[k]) win_idx = IDX_W'(k);
  end
  assign win_cls = live[win_idx].cls;
  // clearing the lowest set bit leaves something only when two or more objects overlap
  assign multi = |(hit1 & (hit1 - N_OBJ'(1)));
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      hit1 <= '0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      de1 <= 1'b0;
      commit1 <= 1'b0;
      acc <= '0;
      o_HSync <= 1'b1;
      o_VSync <= 1'b1;
      o_De <= 1'b0;
      o_FrameStart <= 1'b0;
      o_Hit <= 1'b0;
      o_Collide <= 1'b0;
      o_ObjIdx <= '0;
      o_pixelState <= '0;
      o_CollideMask <= '0;
    end else begin
      hit1 <= hit_d;
      hs1 <= hsync_n;
      vs1 <= vsync_n;
      de1 <= visible;
      commit1 <= commit;
      o_HSync <= hs1;
      o_VSync <= vs1;
      o_De <= de1;
      o_FrameStart <= commit1;
      o_Hit <= |hit1;
      o_Collide <= multi;
      o_ObjIdx <= win_idx;
      o_pixelState <= |hit1 ? CLASS_W'(win_cls) : CLASS_W'(CLS_BG);
      acc <= commit ? '0 : multi ? acc | hit1 : acc;
      o_CollideMask <= commit ? acc : o_CollideMask;
    end
  end
endmodule
